// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 matrix-multiply scheduler.
package matmul_pkg;

  localparam int ELEM_W = 16;
  localparam int MAT_W  = 9 * ELEM_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // LSB position of element (i,j) inside a packed matrix
  function automatic int elem_lsb(input int i, input int j);
    return (i * 3 + j) * ELEM_W;
  endfunction

endpackage

// File: rtl/matmul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the requester after i_rr_ptr has top priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valid
);

  // scan rr_ptr+1, rr_ptr+2, ... modulo N_REQ; the first set request wins
  always_comb begin
    int w_pos;
    o_grant = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = (int'(i_rr_ptr) + k) % N_REQ;
      if (!o_valid && i_req[w_pos[IW-1:0]]) begin
        o_grant[w_pos[IW-1:0]] = 1'b1;
        o_valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// Shares one 3x3 matrix-multiply engine among N_REQ requesters with a watchdog.
//
// state  | meaning
// IDLE   | arbitrate; capture winner operands into eng_a/eng_b
// LAUNCH | ack + eng_start pulse to/for the owner, watchdog = 0
// WAIT   | watchdog counts; leave on eng_done or timeout
// RESP   | resp_valid pulse to owner, op_count update
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*MAT_W-1:0] i_req_a,
  input  logic [N_REQ*MAT_W-1:0] i_req_b,
  output logic [N_REQ-1:0]       o_ack,
  output logic [N_REQ-1:0]       o_resp_valid,
  output logic [MAT_W-1:0]       o_resp_data,
  output logic                   o_resp_err,
  output logic                   o_eng_start,
  output logic                   o_eng_abort,
  output logic [MAT_W-1:0]       o_eng_a,
  output logic [MAT_W-1:0]       o_eng_b,
  input  logic [MAT_W-1:0]       i_eng_result,
  input  logic                   i_eng_done,
  output logic [15:0]            o_op_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [N_REQ-1:0]   r_owner;
  logic [TO_W-1:0]    r_wdog;
  logic [N_REQ-1:0]   r_ack;
  logic [N_REQ-1:0]   r_resp_valid;
  logic [MAT_W-1:0]   r_resp_data;
  logic               r_resp_err;
  logic               r_eng_start;
  logic               r_eng_abort;
  logic [MAT_W-1:0]   r_eng_a;
  logic [MAT_W-1:0]   r_eng_b;
  logic [15:0]        r_op_count;

  logic [N_REQ-1:0]   w_grant;
  logic               w_grant_vld;
  logic [IW-1:0]      w_win_idx;
  logic [MAT_W-1:0]   w_win_a;
  logic [MAT_W-1:0]   w_win_b;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_valid  (w_grant_vld)
  );

  // turn the one-hot grant into an index and select that requester's operands
  always_comb begin
    w_win_idx = '0;
    w_win_a   = '0;
    w_win_b   = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (w_grant[r]) begin
        w_win_idx = IW'(r);
        w_win_a   = i_req_a[r*MAT_W +: MAT_W];
        w_win_b   = i_req_b[r*MAT_W +: MAT_W];
      end
    end
  end

  // scheduler FSM; the watchdog counts cycles since eng_start (0 in LAUNCH)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= IW'(N_REQ - 1);
      r_owner      <= '0;
      r_wdog       <= '0;
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_eng_start  <= 1'b0;
      r_eng_abort  <= 1'b0;
      r_eng_a      <= '0;
      r_eng_b      <= '0;
      r_op_count   <= '0;
    end else begin
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_eng_start  <= 1'b0;
      r_eng_abort  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_owner     <= w_grant;
            r_rr_ptr    <= w_win_idx;
            r_eng_a     <= w_win_a;
            r_eng_b     <= w_win_b;
            r_ack       <= w_grant;
            r_eng_start <= 1'b1;
            r_wdog      <= '0;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_wdog  <= r_wdog + 1'b1;
          r_state <= WAIT;
        end
        WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (i_eng_done) begin
            r_resp_data  <= i_eng_result;
            r_resp_err   <= 1'b0;
            r_resp_valid <= r_owner;
            r_state      <= RESP;
          end else if (r_wdog == TO_W'(TIMEOUT - 1)) begin
            r_eng_abort  <= 1'b1;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= r_owner;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (!r_resp_err && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_eng_start  = r_eng_start;
  assign o_eng_abort  = r_eng_abort;
  assign o_eng_a      = r_eng_a;
  assign o_eng_b      = r_eng_b;
  assign o_op_count   = r_op_count;

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched; the bench itself plays the matrix engine.
module tb_matmul_sched;
  import matmul_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*MAT_W-1:0] req_a;
  logic [N_REQ*MAT_W-1:0] req_b;
  logic [N_REQ-1:0]       ack;
  logic [N_REQ-1:0]       resp_valid;
  logic [MAT_W-1:0]       resp_data;
  logic                   resp_err;
  logic                   eng_start;
  logic                   eng_abort;
  logic [MAT_W-1:0]       eng_a;
  logic [MAT_W-1:0]       eng_b;
  logic [MAT_W-1:0]       eng_result;
  logic                   eng_done;
  logic [15:0]            op_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  matmul_sched #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_ack        (ack),
    .o_resp_valid (resp_valid),
    .o_resp_data  (resp_data),
    .o_resp_err   (resp_err),
    .o_eng_start  (eng_start),
    .o_eng_abort  (eng_abort),
    .o_eng_a      (eng_a),
    .o_eng_b      (eng_b),
    .i_eng_result (eng_result),
    .i_eng_done   (eng_done),
    .o_op_count   (op_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [MAT_W-1:0] oh(input int r);
    return MAT_W'(1) << r;
  endfunction

  function automatic logic [MAT_W-1:0] mat_seq(input int base);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[elem_lsb(i, j) +: ELEM_W] = 16'(base + i * 3 + j);
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] mat_ident();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) m[elem_lsb(i, i) +: ELEM_W] = 16'd1;
    return m;
  endfunction

  // engine model: plain 3x3 product, 16-bit wrap-around
  function automatic logic [MAT_W-1:0] mm(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] c;
    logic [15:0]      acc;
    c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        acc = '0;
        for (int k = 0; k < 3; k++)
          acc = acc + 16'(a[elem_lsb(i, k) +: ELEM_W] * b[elem_lsb(k, j) +: ELEM_W]);
        c[elem_lsb(i, j) +: ELEM_W] = acc;
      end
    return c;
  endfunction

  task automatic set_slot(input int r, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    req_a[r*MAT_W +: MAT_W] = a;
    req_b[r*MAT_W +: MAT_W] = b;
  endtask

  // bounded wait for eng_start, then check the owner's ack and operand capture
  task automatic wait_start(input string tag, input int exp_owner);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (eng_start) seen = 1'b1;
    end
    chk({tag, "_start_seen"}, MAT_W'(seen), MAT_W'(1));
    if (seen) begin
      chk({tag, "_ack"}, MAT_W'(ack), oh(exp_owner));
      chk({tag, "_eng_a"}, eng_a, req_a[exp_owner*MAT_W +: MAT_W]);
    end
  endtask

  // engine answers d cycles after the LAUNCH cycle; expect the response next cycle
  task automatic serve(input string tag, input int d, input logic [MAT_W-1:0] res, input int exp_owner);
    repeat (d) tick();
    eng_done   = 1'b1;
    eng_result = res;
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
    chk({tag, "_resp_valid"}, MAT_W'(resp_valid), oh(exp_owner));
    chk({tag, "_resp_data"}, resp_data, res);
    chk({tag, "_resp_err"}, MAT_W'(resp_err), MAT_W'(0));
    chk({tag, "_no_abort"}, MAT_W'(eng_abort), MAT_W'(0));
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req_a      = '0;
    req_b      = '0;
    eng_done   = 1'b0;
    eng_result = '0;

    // reset values
    tick(); tick();
    chk("rst_ack", MAT_W'(ack), MAT_W'(0));
    chk("rst_resp", MAT_W'({resp_valid, resp_err, eng_start, eng_abort}), MAT_W'(0));
    chk("rst_resp_data", resp_data, MAT_W'(0));
    chk("rst_eng_a", eng_a, MAT_W'(0));
    chk("rst_op_count", MAT_W'(op_count), MAT_W'(0));
    rst_n = 1'b1;
    tick();

    // single request: identity * (1..9)
    set_slot(0, mat_ident(), mat_seq(1));
    req = 4'b0001;
    tick();
    chk("single_ack", MAT_W'(ack), MAT_W'(4'b0001));
    chk("single_start", MAT_W'(eng_start), MAT_W'(1));
    chk("single_eng_a", eng_a, mat_ident());
    chk("single_eng_b", eng_b, mat_seq(1));
    req = '0;
    serve("single", 9, mm(mat_ident(), mat_seq(1)), 0);
    chk("single_data_is_B", resp_data, mat_seq(1));
    chk("single_op_count", MAT_W'(op_count), MAT_W'(1));

    // done while IDLE is ignored
    eng_done = 1'b1;
    eng_result = mat_seq(500);
    tick();
    eng_done = 1'b0;
    chk("idle_done_ignored", MAT_W'(resp_valid), MAT_W'(0));
    chk("idle_done_count", MAT_W'(op_count), MAT_W'(1));

    // fresh reset so the pointer starts at N_REQ-1
    rst_n = 1'b0;
    tick();
    chk("rst2_op_count", MAT_W'(op_count), MAT_W'(0));
    rst_n = 1'b1;
    for (int r = 0; r < N_REQ; r++) set_slot(r, mat_seq(16 * r + 1), mat_seq(16 * r + 100));

    // contention: all four held, expect 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("rr%0d", k), k % 4);
      if (k == 4) req = '0;
      serve($sformatf("rr%0d", k), 2, mat_seq(1000 + k), k % 4);
    end
    chk("rr_op_count", MAT_W'(op_count), MAT_W'(5));

    // pointer skip: serve 1, then lone 0, then 2 before 0 when both pending
    req = 4'b0010;
    wait_start("skip1", 1);
    req = '0;
    serve("skip1", 3, mat_seq(2000), 1);
    req = 4'b0001;
    wait_start("skip0", 0);
    req = '0;
    serve("skip0", 3, mat_seq(2100), 0);
    req = 4'b0101;
    wait_start("skip2", 2);
    req = 4'b0001;
    serve("skip2", 3, mat_seq(2200), 2);
    wait_start("skip0b", 0);
    req = '0;
    serve("skip0b", 3, mat_seq(2300), 0);
    chk("skip_op_count", MAT_W'(op_count), MAT_W'(9));

    // timeout: engine never answers
    req = 4'b1000;
    wait_start("to", 3);
    req = '0;
    repeat (TIMEOUT - 1) tick();
    chk("to_pre_abort", MAT_W'({eng_abort, resp_valid}), MAT_W'(0));
    tick();
    chk("to_abort", MAT_W'(eng_abort), MAT_W'(1));
    chk("to_resp_valid", MAT_W'(resp_valid), MAT_W'(4'b1000));
    chk("to_resp_err", MAT_W'(resp_err), MAT_W'(1));
    chk("to_resp_data", resp_data, MAT_W'(0));
    tick();
    chk("to_abort_end", MAT_W'(eng_abort), MAT_W'(0));
    chk("to_op_count", MAT_W'(op_count), MAT_W'(9));

    // done exactly on the watchdog terminal cycle: done wins
    req = 4'b0100;
    wait_start("coll", 2);
    req = '0;
    serve("coll", TIMEOUT - 1, mat_seq(3000), 2);
    chk("coll_op_count", MAT_W'(op_count), MAT_W'(10));

    // reset mid-WAIT with requests 0 and 3 held
    req = 4'b1001;
    wait_start("rstw_pre", 3);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("rstw_ack_resp", MAT_W'({ack, resp_valid, resp_err, eng_start, eng_abort}), MAT_W'(0));
    chk("rstw_resp_data", resp_data, MAT_W'(0));
    chk("rstw_eng_b", eng_b, MAT_W'(0));
    chk("rstw_op_count", MAT_W'(op_count), MAT_W'(0));
    rst_n = 1'b1;
    wait_start("rstw_post", 0);
    req = '0;
    serve("rstw_post", 2, mat_seq(4000), 0);
    chk("rstw_post_count", MAT_W'(op_count), MAT_W'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
